instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 205 ++++++++++++++++++++
 tb/tb_instr_encoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: turns abstract ALU/memory requests into ARM or RISC-V
// machine words, inserting ISA marker words whenever the target ISA changes.
module instr_encoder #(
    parameter bit FIRST_MARKER = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_isa,
    input  logic [3:0]  in_op,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_rn,
    input  logic [3:0]  in_rm,
    input  logic        in_imm,
    input  logic [7:0]  in_offset,
    input  logic [1:0]  in_cond,
    input  logic        in_setflags,
    input  logic        resync,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_cmd,
    output logic        out_is_marker,
    output logic        err_pulse,
    output logic [7:0]  err_count
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic        hold_isa_q, hold_isa_d;
    logic        cur_isa_q, cur_isa_d;
    logic        known_q, known_d;
    logic        pend_q, pend_d;
    logic        out_valid_d, out_is_marker_d, err_pulse_d;
    logic [31:0] out_cmd_d;
    logic [7:0]  err_count_d;

    logic [3:0]  cond_f, dp_opc;
    logic [2:0]  rv_f3;
    logic        s_bit;
    logic [31:0] arm_word, rv_word, word;
    logic        arm_ok, rv_ok, legal, need_mk, accept;

    assign in_ready = (state_q == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Field lookup tables shared by both encoders
    always_comb begin
        unique case (in_cond)
            2'b00: cond_f = 4'b0000;
            2'b01: cond_f = 4'b0100;
            2'b10: cond_f = 4'b0010;
            2'b11: cond_f = 4'b1110;
        endcase
        case (in_op[2:0])
            3'd0:    dp_opc = 4'b0000;
            3'd1:    dp_opc = 4'b0001;
            3'd2:    dp_opc = 4'b0010;
            3'd3:    dp_opc = 4'b0100;
            3'd4:    dp_opc = 4'b1010;
            3'd5:    dp_opc = 4'b1011;
            3'd6:    dp_opc = 4'b1101;
            default: dp_opc = 4'b0000;
        endcase
        case (in_op[1:0])
            2'd0:    rv_f3 = 3'b111;
            2'd1:    rv_f3 = 3'b100;
            default: rv_f3 = 3'b000;
        endcase
        s_bit = in_setflags | (in_op == 4'd4) | (in_op == 4'd5);
    end

    // ARM encoding; words colliding with marker values are rejected
    always_comb begin
        arm_word = '0;
        arm_ok   = 1'b1;
        unique case (1'b1)
            (in_op <= 4'd6):
                arm_word = {cond_f, 2'b00, in_imm, dp_opc, s_bit,
                            in_rn, in_rd,
                            in_imm ? {4'b0, in_offset} : {8'b0, in_rm}};
            (in_op == 4'd7):
                arm_word = {cond_f, 3'b101, 1'b0, 16'b0, in_offset};
            (in_op[3:1] == 3'b100): begin
                arm_word = {cond_f, 2'b01, 1'b1, 4'b0, ~in_op[0], in_rn,
                            in_op[0] ? in_rm : in_rd, 4'b0, in_offset};
                arm_ok   = in_imm;
            end
            (in_op >= 4'd10):
                arm_word = {cond_f, 4'b1111, 24'b0};
        endcase
        if (arm_word[31:1] == 31'd0) arm_ok = 1'b0;
    end

    // RISC-V encoding
    always_comb begin
        rv_word = '0;
        rv_ok   = 1'b1;
        unique case (1'b1)
            (in_op <= 4'd3): begin
                if (in_imm) begin
                    rv_word = {4'b0, in_offset, 1'b0, in_rn, rv_f3,
                               1'b0, in_rd, 7'b0010011};
                    rv_ok   = (in_op != 4'd2);
                end else begin
                    rv_word = {1'b0, in_op == 4'd2, 5'b0, 1'b0, in_rm,
                               1'b0, in_rn, rv_f3, 1'b0, in_rd,
                               7'b0110011};
                end
            end
            (in_op == 4'd8):
                rv_word = {4'b0, in_offset, 1'b0, in_rn, 3'b010,
                           1'b0, in_rd, 7'b0000011};
            (in_op == 4'd9):
                rv_word = {4'b0, in_offset[7:5], 1'b0, in_rm, 1'b0, in_rn,
                           3'b010, in_offset[4:0], 7'b0100011};
            (in_op[3:1] == 3'b101):
                rv_word = {3'b0, in_offset[7:4], 1'b0, in_rm, 1'b0, in_rn,
                           2'b00, in_op[0], in_offset[3:0], 1'b0,
                           7'b1100011};
            default: rv_ok = 1'b0;
        endcase
    end

    assign word    = in_isa ? rv_word : arm_word;
    assign legal   = in_isa ? rv_ok : arm_ok;
    assign need_mk = (in_isa != cur_isa_q) | ~known_q | pend_q | resync;

    // Next-state and output decision
    always_comb begin
        state_d         = state_q;
        hold_d          = hold_q;
        hold_isa_d      = hold_isa_q;
        cur_isa_d       = cur_isa_q;
        known_d         = known_q;
        pend_d          = pend_q | resync;
        out_valid_d     = out_valid && !out_ready;
        out_cmd_d       = out_cmd;
        out_is_marker_d = out_is_marker;
        err_pulse_d     = 1'b0;
        err_count_d     = err_count;
        unique case (state_q)
            IDLE: begin
                if (accept && !legal) begin
                    err_pulse_d = 1'b1;
                    if (err_count != 8'hFF) err_count_d = err_count + 8'd1;
                end else if (accept && need_mk) begin
                    out_valid_d     = 1'b1;
                    out_cmd_d       = {31'd0, in_isa};
                    out_is_marker_d = 1'b1;
                    hold_d          = word;
                    hold_isa_d      = in_isa;
                    pend_d          = 1'b0;
                    state_d         = HOLD;
                end else if (accept) begin
                    out_valid_d     = 1'b1;
                    out_cmd_d       = word;
                    out_is_marker_d = 1'b0;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d     = 1'b1;
                    out_cmd_d       = hold_q;
                    out_is_marker_d = 1'b0;
                    cur_isa_d       = hold_isa_q;
                    known_d         = 1'b1;
                    state_d         = IDLE;
                end
            end
        endcase
    end

    // State register; reset drops any held word
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            hold_isa_q    <= 1'b0;
            cur_isa_q     <= 1'b0;
            known_q       <= !FIRST_MARKER;
            pend_q        <= 1'b0;
            out_valid     <= 1'b0;
            out_cmd       <= '0;
            out_is_marker <= 1'b0;
            err_pulse     <= 1'b0;
            err_count     <= '0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            hold_isa_q    <= hold_isa_d;
            cur_isa_q     <= cur_isa_d;
            known_q       <= known_d;
            pend_q        <= pend_d;
            out_valid     <= out_valid_d;
            out_cmd       <= out_cmd_d;
            out_is_marker <= out_is_marker_d;
            err_pulse     <= err_pulse_d;
            err_count     <= err_count_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors plus randomized traffic checked
// against an arithmetic reference encoder and a marker/ISA scoreboard.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_isa = 1'b0;
    logic [3:0]  in_op = '0, in_rd = '0, in_rn = '0, in_rm = '0;
    logic        in_imm = 1'b0;
    logic [7:0]  in_offset = '0;
    logic [1:0]  in_cond = '0;
    logic        in_setflags = 1'b0;
    logic        resync = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_cmd;
    logic        out_is_marker;
    logic        err_pulse;
    logic [7:0]  err_count;

    instr_encoder dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_isa(in_isa), .in_op(in_op),
        .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
        .in_imm(in_imm), .in_offset(in_offset),
        .in_cond(in_cond), .in_setflags(in_setflags),
        .resync(resync),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cmd(out_cmd), .out_is_marker(out_is_marker),
        .err_pulse(err_pulse), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [32:0] exp_q[$];
    bit          use_model = 0;
    bit          m_cur, m_known, m_pend, exp_pulse;
    int          m_err;

    task automatic check(input string tag, input logic [32:0] got,
                         input logic [32:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference encoder built from the field rules with plain arithmetic
    function automatic void ref_enc(input bit isa, input int unsigned op,
        input int unsigned rd, input int unsigned rn, input int unsigned rm,
        input bit imm, input int unsigned off, input int unsigned cond,
        input bit s, output logic [31:0] w, output bit ok);
        int unsigned ct[4] = '{0, 4, 2, 14};
        int unsigned ot[7] = '{0, 1, 2, 4, 10, 11, 13};
        int unsigned ft[4] = '{7, 4, 0, 0};
        int unsigned c, v, ii, sf;
        ok = 1; v = 0; c = ct[cond]; ii = imm;
        if (!isa) begin
            if (op <= 6) begin
                sf = (s || op == 4 || op == 5) ? 1 : 0;
                v = c * 2**28 + ii * 2**25 + ot[op] * 2**21 + sf * 2**20
                  + rn * 2**16 + rd * 2**12 + (imm ? off : rm);
            end else if (op == 7) begin
                v = c * 2**28 + 5 * 2**25 + off;
            end else if (op == 8 || op == 9) begin
                v = c * 2**28 + 3 * 2**25 + (op == 8 ? 2**20 : 0)
                  + rn * 2**16 + (op == 8 ? rd : rm) * 2**12 + off;
                ok = imm;
            end else begin
                v = c * 2**28 + 15 * 2**24;
            end
            if (v <= 1) ok = 0;
        end else begin
            if (op <= 3 && imm) begin
                v = off * 2**20 + rn * 2**15 + ft[op] * 2**12
                  + rd * 2**7 + 'h13;
                ok = (op != 2);
            end else if (op <= 3) begin
                v = (op == 2 ? 2**30 : 0) + rm * 2**20 + rn * 2**15
                  + ft[op] * 2**12 + rd * 2**7 + 'h33;
            end else if (op == 8) begin
                v = off * 2**20 + rn * 2**15 + 2 * 2**12 + rd * 2**7 + 3;
            end else if (op == 9) begin
                v = (off / 32) * 2**25 + rm * 2**20 + rn * 2**15
                  + 2 * 2**12 + (off % 32) * 2**7 + 'h23;
            end else if (op == 10 || op == 11) begin
                v = (off / 16) * 2**25 + rm * 2**20 + rn * 2**15
                  + (op - 10) * 2**12 + (off % 16) * 2**8 + 'h63;
            end else begin
                ok = 0;
            end
        end
        w = v;
    endfunction

    task automatic model_accept();
        logic [31:0] w;
        bit ok;
        ref_enc(in_isa, in_op, in_rd, in_rn, in_rm, in_imm, in_offset,
                in_cond, in_setflags, w, ok);
        if (!ok) begin
            if (m_err < 255) m_err++;
            exp_pulse = 1;
            if (resync) m_pend = 1;
        end else begin
            if (in_isa != m_cur || !m_known || m_pend || resync)
                exp_q.push_back({1'b1, 31'd0, in_isa});
            m_cur = in_isa; m_known = 1; m_pend = 0;
            exp_q.push_back({1'b0, w});
        end
    endtask

    // One clock: sample handshakes, score outputs, advance to next low phase
    task automatic tick(output bit acc);
        bit oh;
        logic [32:0] e;
        #1;
        acc = in_valid && in_ready;
        oh  = out_valid && out_ready;
        if (oh) begin
            check("out_expected", 33'(exp_q.size() != 0), 33'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_word", {out_is_marker, out_cmd}, e);
            end
        end
        if (use_model) begin
            check("err_pulse", 33'(err_pulse), 33'(exp_pulse));
            check("err_count", 33'(err_count), 33'(m_err));
            exp_pulse = 0;
            if (acc) model_accept();
            else if (resync) m_pend = 1;
        end
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        bit a;
        for (int i = 0; i < n; i++) tick(a);
    endtask

    task automatic send(input bit isa, input logic [3:0] op,
        input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm,
        input bit imm, input logic [7:0] off, input logic [1:0] cond,
        input bit s);
        bit acc;
        in_isa = isa; in_op = op; in_rd = rd; in_rn = rn; in_rm = rm;
        in_imm = imm; in_offset = off; in_cond = cond; in_setflags = s;
        in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 20 && !acc; i++) tick(acc);
        in_valid = 1'b0;
        check("send_accepted", 33'(acc), 33'd1);
    endtask

    initial begin
        bit a;
        @(negedge clk);
        drain(2);
        check("rst_valid", 33'(out_valid), 33'd0);
        check("rst_cmd", 33'(out_cmd), 33'd0);
        check("rst_marker", 33'(out_is_marker), 33'd0);
        check("rst_errp", 33'(err_pulse), 33'd0);
        check("rst_errc", 33'(err_count), 33'd0);
        check("rst_ready", 33'(in_ready), 33'd1);
        reset = 1'b0;

        exp_q.push_back({1'b1, 32'h0});
        exp_q.push_back({1'b0, 32'hE2821005});
        send(0, 4'd3, 4'd1, 4'd2, 4'd0, 1, 8'h05, 2'b11, 0);
        drain(3);

        exp_q.push_back({1'b1, 32'h1});
        exp_q.push_back({1'b0, 32'h002081B3});
        send(1, 4'd3, 4'd3, 4'd1, 4'd2, 0, 8'h00, 2'b00, 0);
        drain(3);
        exp_q.push_back({1'b0, 32'h002081B3});
        send(1, 4'd3, 4'd3, 4'd1, 4'd2, 0, 8'h00, 2'b00, 0);
        check("lat1_word", {out_valid, out_is_marker, out_cmd},
              {2'b10, 32'h002081B3});
        drain(2);

        exp_q.push_back({1'b0, 32'h02512223});
        send(1, 4'd9, 4'd0, 4'd2, 4'd5, 0, 8'h24, 2'b00, 0);
        drain(2);
        exp_q.push_back({1'b0, 32'h0A208A63});
        send(1, 4'd10, 4'd0, 4'd1, 4'd2, 0, 8'h5A, 2'b00, 0);
        drain(2);
        check("q_empty1", 33'(exp_q.size()), 33'd0);

        send(0, 4'd0, 4'd0, 4'd0, 4'd1, 0, 8'h00, 2'b00, 0);
        check("ill_pulse", 33'(err_pulse), 33'd1);
        check("ill_count1", 33'(err_count), 33'd1);
        check("ill_novalid", 33'(out_valid), 33'd0);
        drain(1);
        check("ill_pulse_end", 33'(err_pulse), 33'd0);
        send(1, 4'd2, 4'd1, 4'd1, 4'd0, 1, 8'h03, 2'b00, 0);
        check("ill_count2", 33'(err_count), 33'd2);
        drain(2);

        out_ready = 1'b0;
        exp_q.push_back({1'b1, 32'h0});
        exp_q.push_back({1'b0, 32'hE3A0307F});
        send(0, 4'd6, 4'd3, 4'd0, 4'd0, 1, 8'h7F, 2'b11, 0);
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", 33'(in_ready), 33'd0);
            check("stall_cmd", {out_valid, out_is_marker, out_cmd},
                  {2'b11, 32'h0});
            tick(a);
        end
        out_ready = 1'b1;
        tick(a);
        check("release_word", {out_valid, out_is_marker, out_cmd},
              {2'b10, 32'hE3A0307F});
        drain(2);
        check("q_empty2", 33'(exp_q.size()), 33'd0);

        out_ready = 1'b0;
        send(1, 4'd3, 4'd3, 4'd1, 4'd2, 0, 8'h00, 2'b00, 0);
        reset = 1'b1;
        tick(a);
        reset = 1'b0;
        check("hrst_valid", 33'(out_valid), 33'd0);
        check("hrst_ready", 33'(in_ready), 33'd1);
        check("hrst_errc", 33'(err_count), 33'd0);
        out_ready = 1'b1;
        drain(3);

        reset = 1'b1;
        drain(2);
        reset = 1'b0;
        use_model = 1;
        m_cur = 0; m_known = 0; m_pend = 0; m_err = 0; exp_pulse = 0;
        for (int i = 0; i < 500; i++) begin
            in_valid    = ($urandom % 4) != 0;
            in_isa      = 1'($urandom);
            in_op       = 4'($urandom_range(0, 11));
            in_rd       = 4'($urandom);
            in_rn       = 4'($urandom);
            in_rm       = 4'($urandom);
            in_imm      = 1'($urandom);
            in_offset   = 8'($urandom);
            in_cond     = 2'($urandom);
            in_setflags = 1'($urandom);
            resync      = ($urandom % 12) == 0;
            out_ready   = ($urandom % 4) != 0;
            tick(a);
        end
        in_valid = 1'b0; resync = 1'b0; out_ready = 1'b1;
        drain(6);
        check("q_empty3", 33'(exp_q.size()), 33'd0);

        in_isa = 1'b1; in_op = 4'd4; in_valid = 1'b1;
        for (int i = 0; i < 300; i++) tick(a);
        in_valid = 1'b0;
        drain(2);
        check("err_saturate", 33'(err_count), 33'd255);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
